// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding, stage
// bit positions for the default 4-deep pipeline, and the zero constant.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_e;

  localparam int STAGE_PC     = 3;
  localparam int STAGE_IF_ID  = 2;
  localparam int STAGE_ID_EX  = 1;
  localparam int STAGE_EX_MEM = 0;

  localparam logic [63:0] ZeroWord = '0;

  // Bits lo..hi set; empty when hi < lo.
  function automatic logic [63:0] range_mask(input int hi, input int lo);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      m[i] = (i >= lo) && (i <= hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_timer.sv
// Counts consecutive stalled cycles, saturating at TIMEOUT; raises a sticky
// timeout flag once the limit is reached, cleared only by reset.
module stall_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_stall,
  output logic o_timeout
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (!i_stall) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == LIMIT) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage hold/flush, PC redirect with a single
// pending slot for redirects that arrive while stalled, and load-use bubbles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = STAGE_PC + 1,
  parameter int EX_STAGE     = STAGE_ID_EX,
  parameter int ADDR_W       = 32,
  parameter int LOAD_BUBBLES = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_jump_flag,
  input  logic [ADDR_W-1:0]     i_jump_addr,
  input  logic                  i_load_use,
  input  logic                  i_ex_busy,
  input  logic                  i_mem_wait,
  output logic [NUM_STAGES-1:0] o_hold_flag,
  output logic [NUM_STAGES-1:0] o_flush_flag,
  output logic                  o_jump_flag,
  output logic [ADDR_W-1:0]     o_jump_addr,
  output logic                  o_timeout
);

  localparam logic [NUM_STAGES-1:0] ALL_HOLD   = '1;
  localparam logic [NUM_STAGES-1:0] BUSY_HOLD  = NUM_STAGES'(range_mask(NUM_STAGES-1, EX_STAGE));
  localparam logic [NUM_STAGES-1:0] BUSY_FLUSH = NUM_STAGES'(range_mask(EX_STAGE-1, 0));
  localparam logic [NUM_STAGES-1:0] JUMP_FLUSH = NUM_STAGES'(range_mask(NUM_STAGES-2, EX_STAGE));
  localparam logic [NUM_STAGES-1:0] LU_HOLD    = NUM_STAGES'(range_mask(NUM_STAGES-1, EX_STAGE+1));
  localparam logic [NUM_STAGES-1:0] LU_FLUSH   = NUM_STAGES'(range_mask(EX_STAGE, EX_STAGE));
  localparam logic [2:0]            BUB_INIT   = 3'(LOAD_BUBBLES - 1);
  localparam logic [ADDR_W-1:0]     ADDR_ZERO  = ZeroWord[ADDR_W-1:0];

  state_e              state_q, state_d;
  logic [2:0]          bub_q, bub_d;
  logic                pend_v_q, pend_v_d;
  logic [ADDR_W-1:0]   pend_a_q, pend_a_d;

  logic [NUM_STAGES-1:0] hold, flush;
  logic                  jump;
  logic [ADDR_W-1:0]     jump_addr;
  logic                  stalled;
  logic                  timeout;

  always_comb begin
    state_d   = state_q;
    bub_d     = bub_q;
    pend_v_d  = pend_v_q;
    pend_a_d  = pend_a_q;
    hold      = '0;
    flush     = '0;
    jump      = 1'b0;
    jump_addr = ADDR_ZERO;
    stalled   = i_mem_wait | i_ex_busy;

    if (i_mem_wait) begin
      hold = ALL_HOLD;
    end else if (i_ex_busy) begin
      hold  = BUSY_HOLD;
      flush = BUSY_FLUSH;
    end else if (pend_v_q || i_jump_flag) begin
      // A redirect squashes any load-use stall in flight or arriving with it.
      jump      = 1'b1;
      jump_addr = pend_v_q ? pend_a_q : i_jump_addr;
      flush     = JUMP_FLUSH;
      pend_v_d  = 1'b0;
      state_d   = RUN;
      bub_d     = '0;
    end else if (state_q == LOAD_STALL) begin
      hold  = LU_HOLD;
      flush = LU_FLUSH;
      bub_d = bub_q - 1'b1;
      if (bub_q <= 3'd1) begin
        state_d = RUN;
      end
    end else if (i_load_use) begin
      hold  = LU_HOLD;
      flush = LU_FLUSH;
      if (LOAD_BUBBLES > 1) begin
        state_d = LOAD_STALL;
        bub_d   = BUB_INIT;
      end
    end

    // Only the first redirect seen while stalled is kept.
    if (stalled && i_jump_flag && !pend_v_q) begin
      pend_v_d = 1'b1;
      pend_a_d = i_jump_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= RUN;
      bub_q    <= '0;
      pend_v_q <= 1'b0;
      pend_a_q <= ADDR_ZERO;
    end else begin
      state_q  <= state_d;
      bub_q    <= bub_d;
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
    end
  end

  stall_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_stall   (|hold),
    .o_timeout (timeout)
  );

  assign o_hold_flag  = i_reset_n ? hold      : '0;
  assign o_flush_flag = i_reset_n ? flush     : '0;
  assign o_jump_flag  = i_reset_n & jump;
  assign o_jump_addr  = i_reset_n ? jump_addr : ADDR_ZERO;
  assign o_timeout    = timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vector table, multi-cycle corner sequences,
// then randomized traffic compared against a behavioural model.
module tb_pipe_ctrl;

  localparam int NS = 4;
  localparam int EX = 1;
  localparam int AW = 32;
  localparam int LB = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          jf, lu, busy, mw;
  logic [AW-1:0] ja;
  logic [NS-1:0] hold, flush;
  logic          ojf, oto;
  logic [AW-1:0] oja;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .NUM_STAGES   (NS),
    .EX_STAGE     (EX),
    .ADDR_W       (AW),
    .LOAD_BUBBLES (LB),
    .TIMEOUT      (TO)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_jump_flag  (jf),
    .i_jump_addr  (ja),
    .i_load_use   (lu),
    .i_ex_busy    (busy),
    .i_mem_wait   (mw),
    .o_hold_flag  (hold),
    .o_flush_flag (flush),
    .o_jump_flag  (ojf),
    .o_jump_addr  (oja),
    .o_timeout    (oto)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic j, input logic [AW-1:0] a, input logic l,
                       input logic b, input logic m);
    jf = j; ja = a; lu = l; busy = b; mw = m;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          jf;
    logic [AW-1:0] ja;
    logic          lu, busy, mw;
    logic [NS-1:0] hold, flush;
    logic          ojf;
    logic [AW-1:0] oja;
    logic          to;
  } vec_t;

  function automatic vec_t mk(input logic j, input logic [AW-1:0] a, input logic l,
                              input logic b, input logic m, input logic [NS-1:0] h,
                              input logic [NS-1:0] f, input logic oj,
                              input logic [AW-1:0] oa, input logic t);
    vec_t v;
    v.jf = j; v.ja = a; v.lu = l; v.busy = b; v.mw = m;
    v.hold = h; v.flush = f; v.ojf = oj; v.oja = oa; v.to = t;
    return v;
  endfunction

  // Behavioural reference: remaining bubbles as an integer, pending redirect slot.
  logic          m_pv, m_to;
  logic [AW-1:0] m_pa;
  int            m_left, m_cnt;

  task automatic model_reset();
    m_pv = 0; m_pa = '0; m_left = 0; m_cnt = 0; m_to = 0;
  endtask

  task automatic model_outputs(output logic [NS-1:0] eh, output logic [NS-1:0] ef,
                               output logic ej, output logic [AW-1:0] ea);
    eh = '0; ef = '0; ej = 0; ea = '0;
    if (!rst_n) return;
    if (mw) begin
      eh = '1;
    end else if (busy) begin
      for (int i = 0; i < NS; i++) begin eh[i] = (i >= EX); ef[i] = (i < EX); end
    end else if (m_pv || jf) begin
      ej = 1; ea = m_pv ? m_pa : ja;
      for (int i = 0; i < NS; i++) ef[i] = (i >= EX) && (i <= NS - 2);
    end else if (m_left > 0 || lu) begin
      for (int i = 0; i < NS; i++) begin eh[i] = (i > EX); ef[i] = (i == EX); end
    end
  endtask

  task automatic model_edge(input logic [NS-1:0] eh);
    if (!rst_n) return;
    if (mw || busy) begin
      if (jf && !m_pv) begin m_pv = 1; m_pa = ja; end
    end else if (m_pv || jf) begin
      m_pv = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (lu) begin
      m_left = LB - 1;
    end
    m_cnt = (eh != 0) ? ((m_cnt + 1 > TO) ? TO : m_cnt + 1) : 0;
    if (m_cnt == TO) m_to = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t          vt[$];
    logic [NS-1:0] eh, ef;
    logic          ej;
    logic [AW-1:0] ea;

    // Reset with active inputs: everything must read zero.
    rst_n = 0;
    drive(1, 32'hDEAD, 1, 1, 1);
    @(negedge clk);
    check("reset hold", 64'(hold), 64'h0);
    check("reset flush", 64'(flush), 64'h0);
    check("reset jump", {ojf, oja}, 64'h0);
    check("reset timeout", 64'(oto), 64'h0);
    next_cycle();
    rst_n = 1;

    //          jf  ja      lu busy mw  hold     flush    ojf oja     to
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b0000, 4'b0000, 0, 0,      0));
    vt.push_back(mk(0, 0,      1, 0, 0, 4'b1100, 4'b0010, 0, 0,      0));
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b1100, 4'b0010, 0, 0,      0));
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b0000, 4'b0000, 0, 0,      0));
    vt.push_back(mk(1, 'h80,   0, 0, 0, 4'b0000, 4'b0110, 1, 'h80,   0));
    vt.push_back(mk(1, 'h100,  0, 1, 0, 4'b1110, 4'b0001, 0, 0,      0));
    vt.push_back(mk(1, 'h200,  0, 1, 0, 4'b1110, 4'b0001, 0, 0,      0));
    vt.push_back(mk(0, 0,      0, 1, 0, 4'b1110, 4'b0001, 0, 0,      0));
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b0000, 4'b0110, 1, 'h100,  0));
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b0000, 4'b0000, 0, 0,      0));
    vt.push_back(mk(0, 0,      1, 0, 1, 4'b1111, 4'b0000, 0, 0,      0));
    vt.push_back(mk(0, 0,      1, 0, 1, 4'b1111, 4'b0000, 0, 0,      0));
    vt.push_back(mk(0, 0,      1, 0, 0, 4'b1100, 4'b0010, 0, 0,      0));
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b1100, 4'b0010, 0, 0,      0));
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b0000, 4'b0000, 0, 0,      1));
    vt.push_back(mk(0, 0,      1, 0, 0, 4'b1100, 4'b0010, 0, 0,      1));
    vt.push_back(mk(1, 'h44,   0, 0, 0, 4'b0000, 4'b0110, 1, 'h44,   1));
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b0000, 4'b0000, 0, 0,      1));
    vt.push_back(mk(1, 'h48,   1, 0, 0, 4'b0000, 4'b0110, 1, 'h48,   1));
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b0000, 4'b0000, 0, 0,      1));
    vt.push_back(mk(0, 0,      1, 0, 0, 4'b1100, 4'b0010, 0, 0,      1));
    vt.push_back(mk(0, 0,      0, 1, 0, 4'b1110, 4'b0001, 0, 0,      1));
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b1100, 4'b0010, 0, 0,      1));
    vt.push_back(mk(0, 0,      0, 0, 0, 4'b0000, 4'b0000, 0, 0,      1));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].jf, vt[i].ja, vt[i].lu, vt[i].busy, vt[i].mw);
      @(negedge clk);
      check($sformatf("vec%0d hold", i), 64'(hold), 64'(vt[i].hold));
      check($sformatf("vec%0d flush", i), 64'(flush), 64'(vt[i].flush));
      check($sformatf("vec%0d jump", i), {ojf, oja}, {vt[i].ojf, vt[i].oja});
      check($sformatf("vec%0d timeout", i), 64'(oto), 64'(vt[i].to));
      next_cycle();
    end

    // Sticky timeout: reset clears it, four stalled cycles set it.
    drive(0, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    check("timeout cleared by reset", 64'(oto), 64'h0);
    next_cycle();
    rst_n = 1;
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
      check($sformatf("timeout mw cycle%0d", k), 64'(oto), 64'(k >= 5));
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("timeout sticky %0d", k), {hold, oto}, 64'h1);
      next_cycle();
    end

    // Reset in the middle of a load stall with a redirect pending.
    rst_n = 0;
    #1;
    next_cycle();
    rst_n = 1;
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    check("rst seq load", 64'(hold), 64'hC);
    next_cycle();
    drive(1, 32'h300, 0, 1, 0);
    @(negedge clk);
    check("rst seq busy", 64'(hold), 64'hE);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    #2;
    check("rst seq redirect before reset", {ojf, oja}, {1'b1, 32'h300});
    rst_n = 0;
    #1;
    check("rst seq outputs zero", {hold, flush, ojf, oja}, 64'h0);
    next_cycle();
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst seq after release %0d", k), {hold, flush, ojf, oja, oto}, 64'h0);
      next_cycle();
    end

    // Randomized traffic against the reference model.
    rst_n = 0;
    model_reset();
    #1;
    next_cycle();
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      if (!rst_n) model_reset();
      model_outputs(eh, ef, ej, ea);
      @(negedge clk);
      check($sformatf("rand cycle%0d", c), {hold, flush, ojf, oja, oto},
            {eh, ef, ej, ea, m_to});
      @(posedge clk);
      model_edge(eh);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, meaning hold/flush bit count (bit NUM_STAGES-1 = pc, bit 0 = last pipeline register).
REQ-002 SHALL have parameter EX_STAGE, default 1, meaning bit index of the id_ex register.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning jump address width.
REQ-004 SHALL have parameter LOAD_BUBBLES, default 1, range 1..7, meaning stall cycles per load-use hazard.
REQ-005 SHALL have parameter TIMEOUT, default 255, meaning consecutive stall cycles before timeout.
REQ-006 i_clk  in  1  single clock; all state updates on rising edge.
REQ-007 i_reset_n  in  1  asynchronous, active-low reset.
REQ-008 i_jump_flag  in  1  ex requests redirect.
REQ-009 i_jump_addr  in  ADDR_W  redirect target.
REQ-010 i_load_use  in  1  id detects load-use hazard.
REQ-011 i_ex_busy  in  1  multi-cycle ex op in progress.
REQ-012 i_mem_wait  in  1  data bus not ready.
REQ-013 o_hold_flag  out  NUM_STAGES  per-stage hold; held register keeps its value.
REQ-014 o_flush_flag  out  NUM_STAGES  per-stage flush; register loads NOP.
REQ-015 o_jump_flag  out  1  pc redirect strobe.
REQ-016 o_jump_addr  out  ADDR_W  redirect target; zero when o_jump_flag=0.
REQ-017 o_timeout  out  1  sticky stall-timeout flag.

Function
REQ-018 Priority SHALL be i_mem_wait > i_ex_busy > redirect (pending or i_jump_flag) > load-use.
REQ-019 i_mem_wait=1 SHALL hold all bits, flush none, o_jump_flag=0, same cycle (combinational).
REQ-020 i_ex_busy=1 (no mem_wait) SHALL hold bits NUM_STAGES-1..EX_STAGE and flush bits EX_STAGE-1..0.
REQ-021 i_jump_flag=1 during REQ-019/020 SHALL latch i_jump_addr into pend register (pend_valid=1); further i_jump_flag while pend_valid=1 SHALL be ignored.
REQ-022 Redirect, unstalled: o_jump_flag=1, o_jump_addr = pend_addr if pend_valid else i_jump_addr, flush bits NUM_STAGES-2..EX_STAGE, no holds; pend_valid clears that edge.
REQ-023 Redirect SHALL cancel an active or simultaneous load-use stall (FSM to RUN, counter cleared).
REQ-024 FSM states RUN, LOAD_STALL. RUN + i_load_use (no higher priority) -> LOAD_STALL, bubble counter = LOAD_BUBBLES-1.
REQ-025 Load-use cycle (first cycle and each LOAD_STALL cycle) SHALL hold pc and if_id and flush id_ex; in LOAD_STALL counter decrements each unstalled cycle, LOAD_STALL -> RUN when counter is 0.
REQ-026 mem_wait/ex_busy during LOAD_STALL SHALL freeze the counter and FSM.
REQ-027 Stall counter SHALL increment on each cycle with any hold bit set, clear on a cycle with none, saturate at TIMEOUT; reaching TIMEOUT SHALL set o_timeout until reset.
REQ-028 No hazard in RUN: o_hold_flag=0, o_flush_flag=0, o_jump_flag=0, o_jump_addr=0.
REQ-029 A bit SHALL never be held and flushed in the same cycle.

Reset
REQ-030 i_reset_n=0 SHALL asynchronously force FSM=RUN, pend_valid=0, pend_addr=0, bubble and stall counters=0, o_timeout=0; combinational outputs SHALL read zero while in reset.
REQ-031 Reset mid-stall or with pending redirect SHALL discard them; no redirect after release.

Structure
REQ-032 FSM state encodings, stage bit-index constants and ZeroWord SHALL live in the shared defines package.
REQ-033 Stall/timeout counter SHALL be sub-module stall_timer (parameter TIMEOUT).

Verification
REQ-034 i_load_use=1 one cycle, LOAD_BUBBLES=2 -> o_hold_flag=4'b1100, o_flush_flag=4'b0010 for exactly 2 cycles, then 0.
REQ-035 i_jump_flag=1, addr=0x80 unstalled -> same cycle o_jump_flag=1, o_jump_addr=0x80, o_flush_flag=4'b0110.
REQ-036 i_ex_busy=1 3 cycles with i_jump_flag=1 addr=0x100 on first -> o_hold_flag=4'b1110, o_flush_flag=4'b0001 for 3 cycles; 4th cycle o_jump_flag=1, o_jump_addr=0x100.
REQ-037 i_mem_wait=1 and i_load_use=1 simultaneously 2 cycles -> o_hold_flag=4'b1111, flush 0; load-use stall starts on release.
REQ-038 TIMEOUT=4, i_mem_wait=1 for 5 cycles -> o_timeout rises after 4th stall cycle, stays 1 after release until i_reset_n=0.
REQ-039 i_reset_n=0 mid-LOAD_STALL with pending redirect -> all outputs 0 immediately; after release no redirect, RUN.
